// File: rtl/ul_uart_rx_pkg.sv
// Shared types and helpers for the UL UART receive path.
package ul_uart_rx_pkg;

  // Receiver framing states.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreakWait
  } rx_state_e;

  // Receive FIFO geometry: 5-bit pointers wrapping modulo 32, one slot kept free.
  localparam int unsigned FifoPtrW  = 5;
  localparam int unsigned FifoDepth = 31;

  // Minimum counter width able to hold max_val (at least 1 bit).
  function automatic int unsigned cnt_bits(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ul_uart_rx_fifo.sv
// 31-entry synchronous FIFO with fill level, shared by UL peripherals.
module ul_uart_rx_fifo
  import ul_uart_rx_pkg::*;
#(
  parameter int unsigned Width = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [Width-1:0]    wr_data,
  input  logic                rd_en,
  output logic [Width-1:0]    rd_data,
  output logic                wr_done,
  output logic [FifoPtrW-1:0] used,
  output logic                empty,
  output logic                full
);

  localparam logic [FifoPtrW-1:0] PtrOne  = FifoPtrW'(1);
  localparam logic [FifoPtrW-1:0] UsedMax = FifoPtrW'(FifoDepth);

  logic [Width-1:0]    mem_q [2**FifoPtrW];
  logic [FifoPtrW-1:0] wr_ptr_q, rd_ptr_q, used_q;
  logic [FifoPtrW-1:0] used_d;
  logic                rd_done;

  assign empty   = (used_q == '0);
  assign full    = (used_q == UsedMax);
  assign used    = used_q;
  assign rd_done = rd_en && !empty;
  // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
  assign wr_done = wr_en && (!full || rd_done);
  // Head is forced to zero while empty so the bus never sees stale storage.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (wr_done) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

  // Fill level update from accepted push/pop pair.
  always_comb begin
    used_d = used_q;
    unique case ({wr_done, rd_done})
      2'b10:   used_d = used_q + PtrOne;
      2'b01:   used_d = used_q - PtrOne;
      default: used_d = used_q;
    endcase
  end

  // Pointer and level registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      used_q   <= '0;
    end else begin
      if (wr_done) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (rd_done) rd_ptr_q <= rd_ptr_q + PtrOne;
      used_q <= used_d;
    end
  end

endmodule

// File: rtl/ul_uart_rx.sv
// UART receiver: oversampled 8N1-style deframer feeding a 31-entry FIFO with
// level/idle interrupt and sticky framing/overrun errors.
module ul_uart_rx
  import ul_uart_rx_pkg::*;
#(
  parameter int unsigned BITS_DATA         = 8,
  parameter int unsigned UART_SPEED        = 9600,
  parameter int unsigned BUS_SPEED         = 62500000,
  parameter int unsigned GEN_IRQ_WHEN_HAVE = 16,
  parameter int unsigned IDLE_BITS         = 32
) (
  input  logic                 axis_clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [BITS_DATA-1:0] axis_data,
  output logic                 axis_valid,
  input  logic                 axis_ready,
  output logic [4:0]           fifo_used,
  output logic                 fifo_empty,
  output logic                 err_overrun,
  output logic                 err_frame,
  input  logic                 err_clear,
  output logic                 int_valid,
  input  logic                 int_ready
);

  localparam int unsigned Div     = BUS_SPEED / UART_SPEED;
  localparam int unsigned HalfDiv = Div / 2;
  localparam int unsigned CntW    = cnt_bits(Div - 1);
  localparam int unsigned IdxW    = cnt_bits(BITS_DATA - 1);
  localparam int unsigned IdleTc  = IDLE_BITS * Div;
  localparam int unsigned IdleW   = cnt_bits(IdleTc);

  localparam logic [CntW-1:0]  CntFull  = CntW'(Div - 1);
  localparam logic [CntW-1:0]  CntHalf  = CntW'(HalfDiv - 1);
  localparam logic [CntW-1:0]  CntOne   = CntW'(1);
  localparam logic [IdxW-1:0]  IdxLast  = IdxW'(BITS_DATA - 1);
  localparam logic [IdxW-1:0]  IdxOne   = IdxW'(1);
  localparam logic [IdleW-1:0] IdleTerm = IdleW'(IdleTc);
  localparam logic [IdleW-1:0] IdleLast = IdleW'(IdleTc - 1);
  localparam logic [IdleW-1:0] IdleOne  = IdleW'(1);
  localparam logic [4:0]       IrqArm   = 5'(GEN_IRQ_WHEN_HAVE - 1);

  logic [1:0] rst_sync_q;
  logic       rst_n;

  logic rx_meta_q, rxs_q, rxs_prev_q;

  rx_state_e            state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [BITS_DATA-1:0] shift_q, shift_d;
  logic                 push, start_det, frame_err_set;

  logic                 pop, wr_done, fifo_full;
  logic                 overrun_set;
  logic                 err_frame_q, err_frame_d, err_overrun_q, err_overrun_d;

  logic [IdleW-1:0]     idle_q, idle_d;
  logic                 idle_hit, idle_irq, level_irq;
  logic                 int_valid_q, int_valid_d;

  // Reset asserts asynchronously, releases on a clock edge.
  always_ff @(posedge axis_clk or negedge reset) begin
    if (!reset) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_n = rst_sync_q[1];

  // Two-flop synchroniser plus one history flop for falling-edge detection.
  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rxd;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // Deframer next-state: mid-bit sampling driven by a per-bit down counter.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    shift_d       = shift_q;
    push          = 1'b0;
    start_det     = 1'b0;
    frame_err_set = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rxs_q && rxs_prev_q) begin
          state_d   = StStart;
          cnt_d     = CntHalf;
          start_det = 1'b1;
        end
      end
      StStart: begin
        if (cnt_q == '0) begin
          if (!rxs_q) begin
            state_d = StData;
            cnt_d   = CntFull;
            idx_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StData: begin
        if (cnt_q == '0) begin
          shift_d = {rxs_q, shift_q[BITS_DATA-1:1]};
          cnt_d   = CntFull;
          if (idx_q == IdxLast) begin
            state_d = StStop;
          end else begin
            idx_d = idx_q + IdxOne;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StStop: begin
        if (cnt_q == '0) begin
          if (rxs_q) begin
            push    = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_set = 1'b1;
            state_d       = StBreakWait;
          end
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StBreakWait: begin
        // A held-low line yields a single framing error until it returns high.
        if (rxs_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Deframer state registers.
  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  assign pop = axis_valid && axis_ready;

  ul_uart_rx_fifo #(
    .Width (BITS_DATA)
  ) u_fifo (
    .clk     (axis_clk),
    .rst_n   (rst_n),
    .wr_en   (push),
    .wr_data (shift_q),
    .rd_en   (pop),
    .rd_data (axis_data),
    .wr_done (wr_done),
    .used    (fifo_used),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign axis_valid  = !fifo_empty;
  assign overrun_set = push && !wr_done;

  // Sticky errors; a new error in the clear cycle survives.
  always_comb begin
    err_frame_d   = frame_err_set | (err_frame_q & ~err_clear);
    err_overrun_d = overrun_set | (err_overrun_q & ~err_clear);
  end

  // Error flag registers.
  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      err_frame_q   <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      err_frame_q   <= err_frame_d;
      err_overrun_q <= err_overrun_d;
    end
  end

  assign err_frame   = err_frame_q;
  assign err_overrun = err_overrun_q;

  // Idle-line timer; saturating at terminal count gives one event per idle period.
  always_comb begin
    idle_d   = idle_q;
    idle_hit = 1'b0;
    if (start_det || wr_done) begin
      idle_d = '0;
    end else if (state_q == StIdle && rxs_q && idle_q != IdleTerm) begin
      idle_d   = idle_q + IdleOne;
      idle_hit = (idle_q == IdleLast);
    end
  end

  // Idle timer register.
  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_d;
    end
  end

  // Interrupt: level crossing or idle-with-data; a set event beats the ack.
  always_comb begin
    idle_irq    = idle_hit && !fifo_empty;
    level_irq   = wr_done && !pop && (fifo_used == IrqArm);
    int_valid_d = idle_irq | level_irq | (int_valid_q & ~int_ready);
  end

  // Interrupt request register.
  always_ff @(posedge axis_clk or negedge rst_n) begin
    if (!rst_n) begin
      int_valid_q <= 1'b0;
    end else begin
      int_valid_q <= int_valid_d;
    end
  end

  assign int_valid = int_valid_q;

endmodule

// File: tb/tb_ul_uart_rx.sv
// Scoreboard bench for ul_uart_rx at 16 clocks per bit.
module tb_ul_uart_rx;

  localparam int unsigned Div       = 16;
  localparam int unsigned IdleBits  = 32;
  localparam int unsigned IrqLevel  = 4;

  logic       axis_clk;
  logic       reset;
  logic       rxd;
  logic [7:0] axis_data;
  logic       axis_valid;
  logic       axis_ready;
  logic [4:0] fifo_used;
  logic       fifo_empty;
  logic       err_overrun;
  logic       err_frame;
  logic       err_clear;
  logic       int_valid;
  logic       int_ready;

  int n_vec = 0;
  int n_err = 0;
  logic [7:0] sb[$];

  ul_uart_rx #(
    .BITS_DATA         (8),
    .UART_SPEED        (1000000),
    .BUS_SPEED         (16000000),
    .GEN_IRQ_WHEN_HAVE (IrqLevel),
    .IDLE_BITS         (IdleBits)
  ) dut (
    .axis_clk    (axis_clk),
    .reset       (reset),
    .rxd         (rxd),
    .axis_data   (axis_data),
    .axis_valid  (axis_valid),
    .axis_ready  (axis_ready),
    .fifo_used   (fifo_used),
    .fifo_empty  (fifo_empty),
    .err_overrun (err_overrun),
    .err_frame   (err_frame),
    .err_clear   (err_clear),
    .int_valid   (int_valid),
    .int_ready   (int_ready)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(posedge axis_clk);
    #1;
  endtask

  // Idle gap, start bit, LSB-first data, then the given stop level (left driven).
  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b1;
    wait_clks(2 * Div);
    rxd = 1'b0;
    wait_clks(Div);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      wait_clks(Div);
    end
    rxd = stop;
    wait_clks(Div);
  endtask

  task automatic send_good(input logic [7:0] b);
    sb.push_back(b);
    send_frame(b, 1'b1);
  endtask

  task automatic pop_check(input string tag);
    int waited;
    logic [7:0] exp;
    waited = 0;
    @(negedge axis_clk);
    while (!axis_valid && waited < 1000) begin
      @(negedge axis_clk);
      waited++;
    end
    check_eq({tag, "_valid"}, axis_valid, 1);
    check_eq({tag, "_sb_has"}, (sb.size() > 0), 1);
    if (sb.size() > 0) begin
      exp = sb.pop_front();
      check_eq(tag, axis_data, exp);
    end
    axis_ready = 1'b1;
    wait_clks(1);
    axis_ready = 1'b0;
  endtask

  task automatic pulse_int_ready();
    int_ready = 1'b1;
    wait_clks(1);
    int_ready = 1'b0;
  endtask

  initial begin
    reset      = 1'b0;
    rxd        = 1'b1;
    axis_ready = 1'b0;
    err_clear  = 1'b0;
    int_ready  = 1'b0;

    // Reset state
    @(negedge axis_clk);
    check_eq("rst_used", fifo_used, 0);
    check_eq("rst_empty", fifo_empty, 1);
    check_eq("rst_valid", axis_valid, 0);
    check_eq("rst_data", axis_data, 0);
    check_eq("rst_errs", {err_frame, err_overrun}, 0);
    check_eq("rst_int", int_valid, 0);
    wait_clks(2);
    reset = 1'b1;
    wait_clks(4);

    // Single good character
    send_good(8'hA5);
    @(negedge axis_clk);
    check_eq("a5_used", fifo_used, 1);
    check_eq("a5_valid", axis_valid, 1);
    check_eq("a5_errs", {err_frame, err_overrun}, 0);
    pop_check("a5_data");

    // Short low glitch is rejected
    rxd = 1'b0;
    wait_clks(5);
    rxd = 1'b1;
    wait_clks(3 * Div);
    @(negedge axis_clk);
    check_eq("glitch_used", fifo_used, 0);
    check_eq("glitch_ferr", err_frame, 0);

    // Bad stop bit followed by a long break
    send_frame(8'h3C, 1'b0);
    wait_clks(40 * Div);
    @(negedge axis_clk);
    check_eq("brk_ferr", err_frame, 1);
    check_eq("brk_used", fifo_used, 0);
    rxd = 1'b1;
    wait_clks(4);
    send_good(8'h55);
    @(negedge axis_clk);
    check_eq("post_brk_used", fifo_used, 1);
    pop_check("post_brk_data");
    check_eq("ferr_sticky", err_frame, 1);
    err_clear = 1'b1;
    wait_clks(1);
    err_clear = 1'b0;
    @(negedge axis_clk);
    check_eq("ferr_clear", err_frame, 0);

    // Level interrupt at the fourth entry
    pulse_int_ready();
    for (int i = 0; i < 3; i++) send_good(8'h10 + 8'(i));
    @(negedge axis_clk);
    check_eq("lvl_below", int_valid, 0);
    send_good(8'h13);
    @(negedge axis_clk);
    check_eq("lvl_used", fifo_used, 4);
    check_eq("lvl_rise", int_valid, 1);
    pulse_int_ready();
    @(negedge axis_clk);
    check_eq("lvl_ack", int_valid, 0);
    send_good(8'h14);
    @(negedge axis_clk);
    check_eq("lvl_fifth", int_valid, 0);
    for (int i = 0; i < 5; i++) pop_check("lvl_pop");

    // Idle interrupt with data pending
    send_good(8'hC3);
    send_good(8'h81);
    @(negedge axis_clk);
    check_eq("idle_early0", int_valid, 0);
    wait_clks(IdleBits * Div - 40);
    @(negedge axis_clk);
    check_eq("idle_early1", int_valid, 0);
    wait_clks(60);
    @(negedge axis_clk);
    check_eq("idle_fire", int_valid, 1);
    pulse_int_ready();
    wait_clks(IdleBits * Div + 100);
    @(negedge axis_clk);
    check_eq("idle_once", int_valid, 0);
    pop_check("idle_pop");
    pop_check("idle_pop");
    wait_clks(50);
    @(negedge axis_clk);
    check_eq("idle_quiet", int_valid, 0);

    // Overrun: 32 characters into 31 slots
    for (int i = 0; i < 32; i++) begin
      if (i < 31) sb.push_back(8'(i));
      send_frame(8'(i), 1'b1);
    end
    @(negedge axis_clk);
    check_eq("ovr_used", fifo_used, 31);
    check_eq("ovr_flag", err_overrun, 1);
    for (int i = 0; i < 31; i++) pop_check("ovr_pop");
    @(negedge axis_clk);
    check_eq("ovr_drained", fifo_empty, 1);
    err_clear = 1'b1;
    wait_clks(1);
    err_clear = 1'b0;
    @(negedge axis_clk);
    check_eq("ovr_clear", err_overrun, 0);
    pulse_int_ready();

    // Reset mid-frame with an entry held
    send_frame(8'h77, 1'b1);
    rxd = 1'b0;
    wait_clks(3 * Div);
    #3;
    reset = 1'b0;
    #1;
    check_eq("mid_rst_used", fifo_used, 0);
    check_eq("mid_rst_valid", axis_valid, 0);
    check_eq("mid_rst_empty", fifo_empty, 1);
    check_eq("mid_rst_data", axis_data, 0);
    wait_clks(2);
    rxd = 1'b1;
    reset = 1'b1;
    wait_clks(10 * Div);
    @(negedge axis_clk);
    check_eq("post_rst_used", fifo_used, 0);
    check_eq("post_rst_ferr", err_frame, 0);
    check_eq("post_rst_int", int_valid, 0);
    check_eq("sb_drained", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ul_uart_rx.md
Name: ul_uart_rx

Overview:
UART receiver front-end for the host register bus: oversamples asynchronous rxd, deframes 8N1-style characters LSB-first and pushes them into a 31-entry receive FIFO read over an AXI-Stream-style handshake. Generates an interrupt when the FIFO reaches a fill threshold or the line goes idle with data pending. Companion of the UART TX path; same bit timing, same FIFO/interrupt conventions.

Parameters:
BITS_DATA, 8, data bits per character
UART_SPEED, 9600, baud rate
BUS_SPEED, 62500000, axis_clk frequency in Hz; DIV = BUS_SPEED/UART_SPEED (integer, >=4) clocks per bit
GEN_IRQ_WHEN_HAVE, 16, fill level (1..31) that raises the interrupt
IDLE_BITS, 32, idle line time in bit periods that raises the interrupt when FIFO non-empty

Ports:
axis_clk  in  1  single clock for all logic
reset  in  1  asynchronous, active-low reset (0 = reset)
rxd  in  1  asynchronous serial input, idle high
axis_data  out  BITS_DATA  received character at FIFO head
axis_valid  out  1  FIFO non-empty
axis_ready  in  1  host pop; pop when axis_valid && axis_ready
fifo_used  out  5  entries held, 0..31
fifo_empty  out  1  fifo_used == 0
err_overrun  out  1  sticky: frame completed while FIFO full
err_frame  out  1  sticky: stop bit sampled low
err_clear  in  1  one-cycle pulse clears both sticky errors
int_valid  out  1  interrupt request
int_ready  in  1  interrupt acknowledge

Behaviour:
- Reset (async assert, sync deassert internally): FSM IDLE, FIFO empty, all outputs 0 except fifo_empty=1; rxd sync flops preset to 1.
- rxd through 2-FF synchronizer; all decisions use synchronized rxs (2-cycle latency).
- FSM: IDLE -> START on rxs falling edge (rxs==0, prev 1); bit counter loaded DIV/2-1.
- START: at counter 0 sample rxs; 0 -> DATA (counter DIV-1, bit index 0); 1 -> IDLE (glitch, nothing recorded).
- DATA: sample every DIV clocks into shift register LSB-first; after BITS_DATA samples -> STOP.
- STOP: sample after DIV; 1 -> write character to FIFO, -> IDLE; 0 -> set err_frame, discard character, -> BREAK_WAIT.
- BREAK_WAIT: stay until rxs==1, then IDLE (breaks produce one framing error, no data).
- FIFO write in the STOP-sample cycle; if fifo_used==31 at that cycle, character dropped, err_overrun set. Simultaneous pop and write while full: pop wins first, write accepted (used stays 31, no overrun).
- Simultaneous push+pop otherwise: fifo_used unchanged. Pointers 5-bit, wrap modulo 32; capacity 31.
- axis_data valid combinationally from FIFO head whenever axis_valid; held stable until popped.
- err_clear in same cycle as a new error: error remains set.
- Idle timer: counts clocks while FSM in IDLE and rxs==1; reset by any start detection or FIFO write; saturates at IDLE_BITS*DIV.
- int_valid set (registered, next cycle) when fifo_used crosses from GEN_IRQ_WHEN_HAVE-1 to >= GEN_IRQ_WHEN_HAVE, or idle timer reaches terminal count with FIFO non-empty (one event per idle period). Cleared on int_valid && int_ready; a set event in the ack cycle wins (stays 1).
- Reset mid-frame: partial character discarded, no error flagged.

Decomposition:
- Shared package: none required; DIV and half-DIV computed as localparams; FSM state encodings local.
- One sub-module natural: ul_uart_rx_fifo (31-entry synchronous FIFO, width BITS_DATA, fifo_used/empty outputs), reused by other UL peripherals.

Test Plan:
- BUS_SPEED=16e6, UART_SPEED=1e6 (DIV=16): send 0xA5 8N1 -> one FIFO entry 0xA5, fifo_used 1, axis_valid 1, no errors.
- Low glitch of 5 clocks on rxd -> FSM returns IDLE, fifo_used stays 0, err_frame 0.
- Send 0x3C with stop bit forced low, then hold rxd low 40 bit-times -> err_frame=1 once, no entry; next valid 0x55 received; err_clear pulse -> err_frame 0.
- Send 32 characters 0x00..0x1F with axis_ready=0 -> fifo_used 31, err_overrun=1, popping returns 0x00..0x1E in order.
- GEN_IRQ_WHEN_HAVE=4: send 4 chars -> int_valid rises after 4th write; int_ready pulse -> int_valid 0; 5th char raises nothing.
- Send 2 chars, idle 32 bit-times -> int_valid asserts once; pop both, stays quiet; reset asserted mid-frame -> all outputs to reset values asynchronously.
